// File: rtl/uart_cfg_fifo_if.sv
// Byte-stream handshake bundle for uart_cfg_fifo.
// TX push side, RX pop side and FIFO occupancy.
interface uart_cfg_fifo_if #(
   parameter int FIFO_DEPTH = 8
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [LW-1:0] tx_level;
   logic          tx_busy;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          rx_frame_err;
   logic          rx_parity_err;
   logic [LW-1:0] rx_level;

   modport master (
      output tx_data, tx_valid, rx_ready,
      input  tx_ready, tx_level, tx_busy,
      input  rx_data, rx_valid, rx_frame_err,
      input  rx_parity_err, rx_level
   );

   modport slave (
      input  tx_data, tx_valid, rx_ready,
      output tx_ready, tx_level, tx_busy,
      output rx_data, rx_valid, rx_frame_err,
      output rx_parity_err, rx_level
   );
endinterface

// File: rtl/uart_cfg_fifo.sv
// Configurable UART with TX and RX byte FIFOs.
// Bit timing and frame format are latched per frame.
module uart_cfg_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [DIV_W-1:0] cfg_sample,
   input  logic [1:0]       cfg_data_bits,
   input  logic [1:0]       cfg_parity,
   input  logic             cfg_stop2,
   uart_cfg_fifo_if.slave   bus,
   output logic             rx_overrun,
   input  logic             ovr_clr,
   input  logic             serial_in,
   output logic             serial_out
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   logic [DIV_W-1:0] per_m1, smp;
   logic [7:0]       mask;
   logic             pen, podd;

   // sample point is clamped so an oversized offset cannot hang RX
   assign per_m1 = (cfg_div < DIV_W'(2)) ? DIV_W'(1) : cfg_div - DIV_W'(1);
   assign smp    = (cfg_sample > per_m1) ? per_m1 : cfg_sample;
   assign mask   = 8'hff >> (2'd3 - cfg_data_bits);
   assign pen    = cfg_parity[0] ^ cfg_parity[1];
   assign podd   = cfg_parity[1];

   logic [7:0]    txf_mem [FIFO_DEPTH];
   logic [AW-1:0] txf_wr, txf_rd;
   logic [LW-1:0] txf_cnt;
   logic [7:0]    txf_head;
   logic          tx_push, tx_load;

   assign bus.tx_ready = (txf_cnt != FULL);
   assign bus.tx_level = txf_cnt;
   assign tx_push      = bus.tx_valid && bus.tx_ready;
   assign txf_head     = txf_mem[txf_rd];

   always_ff @(posedge clk) begin
      if (reset) begin
         txf_wr  <= '0;
         txf_rd  <= '0;
         txf_cnt <= '0;
      end else begin
         if (tx_push) begin
            txf_mem[txf_wr] <= bus.tx_data;
            txf_wr          <= txf_wr + AW'(1);
         end
         if (tx_load) txf_rd <= txf_rd + AW'(1);
         txf_cnt <= txf_cnt + LW'(tx_push) - LW'(tx_load);
      end
   end

   state_e           tx_st, tx_st_d;
   logic [DIV_W-1:0] tx_cnt, tx_cnt_d, tx_pm1;
   logic [2:0]       tx_idx, tx_idx_d, tx_nb;
   logic [7:0]       tx_sh, tx_sh_d;
   logic             tx_sidx, tx_sidx_d, sout_d, tx_end;
   logic             tx_pen, tx_par, tx_stop2;

   assign bus.tx_busy = (tx_st != IDLE);

   always_comb begin
      tx_st_d   = tx_st;
      tx_cnt_d  = tx_cnt;
      tx_idx_d  = tx_idx;
      tx_sh_d   = tx_sh;
      tx_sidx_d = tx_sidx;
      sout_d    = serial_out;
      tx_load   = 1'b0;
      tx_end    = (tx_cnt == tx_pm1);
      if (tx_st != IDLE) tx_cnt_d = tx_end ? '0 : tx_cnt + DIV_W'(1);
      unique case (tx_st)
         IDLE: begin
            sout_d = 1'b1;
            if (txf_cnt != '0) tx_load = 1'b1;
         end
         START: if (tx_end) begin
            tx_st_d  = DATA;
            tx_idx_d = '0;
            sout_d   = tx_sh[0];
         end
         DATA: if (tx_end) begin
            if (tx_idx == tx_nb) begin
               tx_st_d   = tx_pen ? PARITY : STOP;
               tx_sidx_d = 1'b0;
               sout_d    = tx_pen ? tx_par : 1'b1;
            end else begin
               tx_idx_d = tx_idx + 3'd1;
               tx_sh_d  = tx_sh >> 1;
               sout_d   = tx_sh[1];
            end
         end
         PARITY: if (tx_end) begin
            tx_st_d   = STOP;
            tx_sidx_d = 1'b0;
            sout_d    = 1'b1;
         end
         STOP: if (tx_end) begin
            if (tx_stop2 && !tx_sidx) tx_sidx_d = 1'b1;
            else if (txf_cnt != '0) tx_load = 1'b1;
            else begin
               tx_st_d = IDLE;
               sout_d  = 1'b1;
            end
         end
         default: tx_st_d = IDLE;
      endcase
      // next frame starts straight from IDLE or the last stop bit
      if (tx_load) begin
         tx_st_d  = START;
         tx_cnt_d = '0;
         tx_sh_d  = txf_head;
         sout_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_st      <= IDLE;
         tx_cnt     <= '0;
         tx_idx     <= '0;
         tx_sh      <= '0;
         tx_sidx    <= 1'b0;
         serial_out <= 1'b1;
         tx_pm1     <= '0;
         tx_nb      <= '0;
         tx_pen     <= 1'b0;
         tx_par     <= 1'b0;
         tx_stop2   <= 1'b0;
      end else begin
         tx_st      <= tx_st_d;
         tx_cnt     <= tx_cnt_d;
         tx_idx     <= tx_idx_d;
         tx_sh      <= tx_sh_d;
         tx_sidx    <= tx_sidx_d;
         serial_out <= sout_d;
         if (tx_load) begin
            tx_pm1   <= per_m1;
            tx_nb    <= {1'b1, cfg_data_bits};
            tx_pen   <= pen;
            tx_par   <= (^(txf_head & mask)) ^ podd;
            tx_stop2 <= cfg_stop2;
         end
      end
   end

   state_e           rx_st, rx_st_d;
   logic [DIV_W-1:0] rx_cnt, rx_cnt_d, rx_pm1, rx_smp;
   logic [2:0]       rx_idx, rx_idx_d, rx_nb;
   logic [7:0]       rx_sh, rx_sh_d;
   logic             rx_perr, rx_perr_d, rx_pen, rx_podd;
   logic             rx_q, rx_start, rx_push, rx_end, rx_hit;

   always_comb begin
      rx_st_d   = rx_st;
      rx_cnt_d  = rx_cnt;
      rx_idx_d  = rx_idx;
      rx_sh_d   = rx_sh;
      rx_perr_d = rx_perr;
      rx_start  = 1'b0;
      rx_push   = 1'b0;
      rx_end    = (rx_cnt == rx_pm1);
      rx_hit    = (rx_cnt == rx_smp);
      if (rx_st != IDLE) rx_cnt_d = rx_end ? '0 : rx_cnt + DIV_W'(1);
      unique case (rx_st)
         IDLE: if (!rx_q) begin
            rx_start  = 1'b1;
            rx_st_d   = START;
            rx_cnt_d  = '0;
            rx_sh_d   = '0;
            rx_perr_d = 1'b0;
         end
         START: begin
            if (rx_hit && rx_q) rx_st_d = IDLE;
            else if (rx_end) begin
               rx_st_d  = DATA;
               rx_idx_d = '0;
            end
         end
         DATA: begin
            if (rx_hit) rx_sh_d[rx_idx] = rx_q;
            if (rx_end) begin
               if (rx_idx == rx_nb) rx_st_d = rx_pen ? PARITY : STOP;
               else rx_idx_d = rx_idx + 3'd1;
            end
         end
         PARITY: begin
            if (rx_hit) rx_perr_d = rx_q ^ rx_podd ^ (^rx_sh);
            if (rx_end) rx_st_d = STOP;
         end
         STOP: if (rx_hit) begin
            rx_push = 1'b1;
            rx_st_d = IDLE;
         end
         default: rx_st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_q    <= 1'b1;
         rx_st   <= IDLE;
         rx_cnt  <= '0;
         rx_idx  <= '0;
         rx_sh   <= '0;
         rx_perr <= 1'b0;
         rx_pm1  <= '0;
         rx_smp  <= '0;
         rx_nb   <= '0;
         rx_pen  <= 1'b0;
         rx_podd <= 1'b0;
      end else begin
         rx_q    <= serial_in;
         rx_st   <= rx_st_d;
         rx_cnt  <= rx_cnt_d;
         rx_idx  <= rx_idx_d;
         rx_sh   <= rx_sh_d;
         rx_perr <= rx_perr_d;
         if (rx_start) begin
            rx_pm1  <= per_m1;
            rx_smp  <= smp;
            rx_nb   <= {1'b1, cfg_data_bits};
            rx_pen  <= pen;
            rx_podd <= podd;
         end
      end
   end

   logic [9:0]    rxf_mem [FIFO_DEPTH];
   logic [AW-1:0] rxf_wr, rxf_rd;
   logic [LW-1:0] rxf_cnt;
   logic [9:0]    rx_head;
   logic          rx_pop, rxf_full, rx_wr;

   assign bus.rx_valid = (rxf_cnt != '0);
   assign bus.rx_level = rxf_cnt;
   assign rx_pop       = bus.rx_valid && bus.rx_ready;
   assign rxf_full     = (rxf_cnt == FULL);
   assign rx_wr        = rx_push && (!rxf_full || rx_pop);
   assign rx_head      = bus.rx_valid ? rxf_mem[rxf_rd] : '0;
   assign {bus.rx_frame_err, bus.rx_parity_err, bus.rx_data} = rx_head;

   always_ff @(posedge clk) begin
      if (reset) begin
         rxf_wr     <= '0;
         rxf_rd     <= '0;
         rxf_cnt    <= '0;
         rx_overrun <= 1'b0;
      end else begin
         if (rx_wr) begin
            rxf_mem[rxf_wr] <= {~rx_q, rx_perr, rx_sh};
            rxf_wr          <= rxf_wr + AW'(1);
         end
         if (rx_pop) rxf_rd <= rxf_rd + AW'(1);
         rxf_cnt <= rxf_cnt + LW'(rx_wr) - LW'(rx_pop);
         if (rx_push && rxf_full && !rx_pop) rx_overrun <= 1'b1;
         else if (ovr_clr) rx_overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_cfg_fifo.sv
// Testbench for uart_cfg_fifo: vector table, directed corners,
// randomized loopback frames against a bit-list frame model.
module tb_uart_cfg_fifo;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [DW-1:0] cfg_div, cfg_sample;
   logic [1:0]    cfg_data_bits, cfg_parity;
   logic          cfg_stop2;
   logic          ovr_clr, ovr_clr4, rx_overrun, rx_overrun4;
   logic          serial_out, serial_out4, serial_in8, serial_in4;
   logic          loop, sel4, drv;

   uart_cfg_fifo_if #(.FIFO_DEPTH(8)) b8 ();
   uart_cfg_fifo_if #(.FIFO_DEPTH(4)) b4 ();

   assign serial_in8 = loop ? serial_out : (sel4 ? 1'b1 : drv);
   assign serial_in4 = sel4 ? drv : 1'b1;

   uart_cfg_fifo #(.FIFO_DEPTH(8), .DIV_W(DW)) u8 (
      .clk(clk), .reset(reset),
      .cfg_div(cfg_div), .cfg_sample(cfg_sample),
      .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
      .cfg_stop2(cfg_stop2), .bus(b8),
      .rx_overrun(rx_overrun), .ovr_clr(ovr_clr),
      .serial_in(serial_in8), .serial_out(serial_out)
   );

   uart_cfg_fifo #(.FIFO_DEPTH(4), .DIV_W(DW)) u4 (
      .clk(clk), .reset(reset),
      .cfg_div(cfg_div), .cfg_sample(cfg_sample),
      .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
      .cfg_stop2(cfg_stop2), .bus(b4),
      .rx_overrun(rx_overrun4), .ovr_clr(ovr_clr4),
      .serial_in(serial_in4), .serial_out(serial_out4)
   );

   typedef struct {
      logic [7:0] d;
      int         div;
      int         smp;
      logic [1:0] db;
      logic [1:0] par;
      logic       st2;
      logic [7:0] exp_d;
      int         exp_len;
   } vec_t;

   vec_t vt [7];
   int   checks = 0;
   int   errors = 0;
   bit   exp_bits [$];
   int   busy_cnt, wave_bad, exp_len_m;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic int per_of();
      return (cfg_div < 2) ? 2 : int'(cfg_div);
   endfunction

   // line-level model of one frame, one entry per bit period
   task automatic add_frame(input logic [7:0] d);
      int nb, ones;
      nb   = 5 + int'(cfg_data_bits);
      ones = 0;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         exp_bits.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (cfg_parity == 2'b01) exp_bits.push_back(ones % 2 == 1);
      else if (cfg_parity == 2'b10) exp_bits.push_back(ones % 2 == 0);
      exp_bits.push_back(1'b1);
      if (cfg_stop2) exp_bits.push_back(1'b1);
   endtask

   task automatic drive_bits();
      int p;
      p = per_of();
      foreach (exp_bits[k]) begin
         drv = exp_bits[k];
         tick(p);
      end
      drv = 1'b1;
   endtask

   task automatic send(input logic [7:0] d0, input logic [7:0] d1,
                       input int n);
      int p;
      logic [DW-1:0] sv_div;
      logic [1:0]    sv_db, sv_par;
      logic          sv_st2;
      p = per_of();
      exp_bits.delete();
      add_frame(d0);
      if (n == 2) add_frame(d1);
      exp_len_m = exp_bits.size() * p;
      sv_div = cfg_div; sv_db = cfg_data_bits;
      sv_par = cfg_parity; sv_st2 = cfg_stop2;
      b8.tx_data  = d0;
      b8.tx_valid = 1'b1;
      tick(1);
      check("tx_pre_start", serial_out, 1);
      b8.tx_data  = d1;
      b8.tx_valid = (n == 2);
      tick(1);
      b8.tx_valid = 1'b0;
      wave_bad = 0;
      busy_cnt = 0;
      while (b8.tx_busy && busy_cnt < 5000) begin
         if (busy_cnt < exp_len_m && serial_out !== exp_bits[busy_cnt / p])
            wave_bad++;
         if (busy_cnt == p) begin
            cfg_div = sv_div + 3; cfg_data_bits = ~sv_db;
            cfg_parity = ~sv_par; cfg_stop2 = ~sv_st2;
         end
         if (busy_cnt == 2 * p) begin
            cfg_div = sv_div; cfg_data_bits = sv_db;
            cfg_parity = sv_par; cfg_stop2 = sv_st2;
         end
         busy_cnt++;
         tick(1);
      end
      check("tx_wave", wave_bad, 0);
      check("tx_idle_high", serial_out, 1);
   endtask

   task automatic rx_expect(input string tag, input logic [7:0] d,
                            input logic fe, input logic pe);
      check({tag, "_valid"}, b8.rx_valid, 1);
      check({tag, "_data"}, b8.rx_data, d);
      check({tag, "_ferr"}, b8.rx_frame_err, fe);
      check({tag, "_perr"}, b8.rx_parity_err, pe);
      b8.rx_ready = 1'b1;
      tick(1);
      b8.rx_ready = 1'b0;
   endtask

   task automatic set_cfg(input int div, input int smp, input logic [1:0] db,
                          input logic [1:0] par, input logic st2);
      cfg_div = DW'(div); cfg_sample = DW'(smp);
      cfg_data_bits = db; cfg_parity = par; cfg_stop2 = st2;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] d0, d1;
      logic [7:0] q4 [$];
      int         nb;
      int         dv;

      vt[0] = '{8'hA5, 16, 8, 2'd3, 2'b00, 1'b0, 8'hA5, 160};
      vt[1] = '{8'h41, 16, 8, 2'd2, 2'b01, 1'b1, 8'h41, 176};
      vt[2] = '{8'h7F, 16, 8, 2'd2, 2'b01, 1'b1, 8'h7F, 176};
      vt[3] = '{8'hFF,  8, 4, 2'd0, 2'b10, 1'b0, 8'h1F,  64};
      vt[4] = '{8'h3C,  1, 0, 2'd1, 2'b11, 1'b1, 8'h3C,  18};
      vt[5] = '{8'h96,  0, 0, 2'd3, 2'b01, 1'b0, 8'h96,  22};
      vt[6] = '{8'h00,  5, 2, 2'd3, 2'b10, 1'b1, 8'h00,  60};

      set_cfg(16, 8, 2'd3, 2'b00, 1'b0);
      ovr_clr = 0; ovr_clr4 = 0; loop = 0; sel4 = 0; drv = 1;
      b8.tx_data = 0; b8.tx_valid = 0; b8.rx_ready = 0;
      b4.tx_data = 0; b4.tx_valid = 0; b4.rx_ready = 0;
      reset = 1;
      tick(3);
      reset = 0;
      tick(1);
      check("rst_serial_out", serial_out, 1);
      check("rst_tx_ready", b8.tx_ready, 1);
      check("rst_tx_busy", b8.tx_busy, 0);
      check("rst_rx_valid", b8.rx_valid, 0);
      check("rst_overrun", rx_overrun, 0);
      check("rst_tx_level", b8.tx_level, 0);
      check("rst_rx_level", b8.rx_level, 0);
      check("rst_rx_data", b8.rx_data, 0);
      check("rst_flags", {b8.rx_frame_err, b8.rx_parity_err}, 0);

      loop = 1;
      for (int i = 0; i < 7; i++) begin
         set_cfg(vt[i].div, vt[i].smp, vt[i].db, vt[i].par, vt[i].st2);
         send(vt[i].d, 8'h00, 1);
         check("vec_len", busy_cnt, vt[i].exp_len);
         tick(3);
         rx_expect("vec_rx", vt[i].exp_d, 1'b0, 1'b0);
         check("vec_rx_empty", b8.rx_level, 0);
      end

      set_cfg(16, 8, 2'd2, 2'b01, 1'b1);
      send(8'h41, 8'h7F, 2);
      check("b2b_len", busy_cnt, exp_len_m);
      tick(3);
      check("b2b_level", b8.rx_level, 2);
      rx_expect("b2b_0", 8'h41, 1'b0, 1'b0);
      rx_expect("b2b_1", 8'h7F, 1'b0, 1'b0);

      for (int it = 0; it < 6; it++) begin
         dv = int'($urandom_range(2, 12));
         set_cfg(dv, int'($urandom_range(0, dv - 2)), 2'($urandom),
                 2'($urandom), 1'($urandom));
         nb = 5 + int'(cfg_data_bits);
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         send(d0, d1, 2);
         check("rnd_len", busy_cnt, exp_len_m);
         tick(3);
         check("rnd_level", b8.rx_level, 2);
         rx_expect("rnd_0", 8'(d0 & ((1 << nb) - 1)), 1'b0, 1'b0);
         rx_expect("rnd_1", 8'(d1 & ((1 << nb) - 1)), 1'b0, 1'b0);
      end

      loop = 0;
      set_cfg(16, 8, 2'd3, 2'b01, 1'b0);
      exp_bits.delete();
      add_frame(8'h03);
      exp_bits[9] = 1'b1;
      drive_bits();
      tick(4);
      rx_expect("par_err", 8'h03, 1'b0, 1'b1);
      exp_bits.delete();
      add_frame(8'h5A);
      exp_bits[10] = 1'b0;
      drive_bits();
      tick(30);
      check("ferr_level", b8.rx_level, 1);
      rx_expect("frm_err", 8'h5A, 1'b1, 1'b0);

      set_cfg(16, 8, 2'd3, 2'b00, 1'b0);
      drv = 0;
      tick(4);
      drv = 1;
      tick(30);
      check("glitch_level", b8.rx_level, 0);
      exp_bits.delete();
      add_frame(8'hC3);
      drive_bits();
      tick(4);
      rx_expect("post_glitch", 8'hC3, 1'b0, 1'b0);

      sel4 = 1;
      for (int i = 0; i < 5; i++) begin
         d0 = 8'($urandom);
         q4.push_back(d0);
         exp_bits.delete();
         add_frame(d0);
         drive_bits();
         tick(4);
         check("ovr_level", b4.rx_level, (i < 4) ? i + 1 : 4);
         check("ovr_flag", rx_overrun4, (i == 4));
      end
      for (int i = 0; i < 4; i++) begin
         check("ovr_data", b4.rx_data, q4[i]);
         b4.rx_ready = 1'b1;
         tick(1);
         b4.rx_ready = 1'b0;
      end
      check("ovr_sticky", rx_overrun4, 1);
      ovr_clr4 = 1;
      tick(1);
      ovr_clr4 = 0;
      check("ovr_cleared", rx_overrun4, 0);
      sel4 = 0;

      b8.tx_data  = 8'h11;
      b8.tx_valid = 1'b1;
      tick(1);
      b8.tx_valid = 1'b0;
      tick(3);
      check("full_busy", b8.tx_busy, 1);
      for (int i = 0; i < 9; i++) begin
         if (i == 7) check("full_ready_at7", b8.tx_ready, 1);
         b8.tx_data  = 8'(i);
         b8.tx_valid = 1'b1;
         tick(1);
      end
      b8.tx_valid = 1'b0;
      check("full_level", b8.tx_level, 8);
      check("full_ready", b8.tx_ready, 0);

      drv = 0;
      tick(20);
      reset = 1;
      drv = 1;
      tick(1);
      check("midrst_serial_out", serial_out, 1);
      check("midrst_tx_level", b8.tx_level, 0);
      check("midrst_rx_level", b8.rx_level, 0);
      check("midrst_busy", b8.tx_busy, 0);
      reset = 0;
      tick(200);
      check("midrst_rx_discard", b8.rx_level, 0);
      check("midrst_idle_high", serial_out, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_cfg_fifo.md
UART_CFG_FIFO -- requirements
Module: uart_cfg_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning entries per TX and RX FIFO (power of 2, >=2).
REQ-002 SHALL have parameter DIV_W, default 16, meaning the width of the bit-period and sample-point fields.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-004 SHALL have these configuration inputs:
- cfg_div  in  DIV_W  bit period in clk cycles.
- cfg_sample  in  DIV_W  RX sample offset within a bit.
- cfg_data_bits  in  2  00=5 .. 11=8 data bits.
- cfg_parity  in  2  00/11 none, 01 even, 10 odd.
- cfg_stop2  in  1  1 = two TX stop bits.
REQ-005 SHALL have these TX ports: tx_data  in  8  byte; tx_valid  in  1; tx_ready  out  1  (TX FIFO not full); tx_level  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy; tx_busy  out  1  (TX FSM not IDLE).
REQ-006 SHALL have these RX ports: rx_data  out  8; rx_valid  out  1; rx_ready  in  1; rx_frame_err  out  1; rx_parity_err  out  1 (both flags are per head entry); rx_level  out  $clog2(FIFO_DEPTH)+1.
REQ-007 SHALL have these status and serial ports: rx_overrun  out  1  sticky; ovr_clr  in  1; serial_in  in  1; serial_out  out  1.

Function
REQ-008 SHALL register serial_in once before use and drive serial_out from a register.
REQ-009 SHALL use an effective bit period of max(cfg_div,2); a bit boundary occurs when the bit counter equals period-1, after which the counter returns to 0.
REQ-010 SHALL latch all cfg_* fields at frame start (TX and RX independently); cfg changes mid-frame SHALL NOT affect the frame in progress.
REQ-011 SHALL accept a TX push on any cycle with tx_valid && tx_ready; tx_ready SHALL be 0 when the FIFO is full, even if a pop occurs in the same cycle.
REQ-012 SHALL implement the TX FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE with the FIFO non-empty: pop and go to START.
- START: one bit period low.
- DATA: N bits, LSB first.
- PARITY: present only if enabled; even = XOR of the data bits, odd = its inverse.
- STOP: 1 or 2 periods high, then IDLE.
REQ-013 SHALL drive serial_out low from the 2nd rising edge after a push into an empty idle TX path; back-to-back frames SHALL have no idle gap between the last stop bit and the next start bit.
REQ-014 SHALL hold serial_out at 1 whenever the TX FSM is in IDLE.
REQ-015 SHALL implement the RX FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE: a registered serial_in of 0 resets the counter and moves to START.
- START: a line still high at cfg_sample is a false start; return to IDLE and push nothing.
- Data, parity and stop bits are each sampled at cycle cfg_sample of their bit period.
REQ-016 SHALL evaluate only the first stop bit on RX; a 0 there sets frame_err for that byte, and a parity mismatch sets parity_err.
REQ-017 SHALL, at the stop sample, push {frame_err, parity_err, data} to the RX FIFO and return to IDLE in the same cycle.
REQ-018 SHALL zero-fill the unused upper bits of rx_data when fewer than 8 data bits are configured.
REQ-019 SHALL pop the RX FIFO on rx_valid && rx_ready; rx_valid SHALL equal RX FIFO non-empty.
REQ-020 SHALL accept an RX push to a full FIFO only if a pop occurs in the same cycle; otherwise the byte is dropped and rx_overrun is set.
REQ-021 SHALL clear rx_overrun on ovr_clr; if set and clear coincide, set wins.
REQ-022 SHALL wrap the FIFO pointers modulo FIFO_DEPTH; levels range 0..FIFO_DEPTH.

Reset
REQ-023 SHALL, on a reset cycle, put both FSMs in IDLE, empty both FIFOs and zero all counters.
REQ-024 SHALL produce these output values after reset: serial_out=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_overrun=0, levels=0, rx_data=0, both error flags 0.
REQ-025 SHALL abort any frame on a mid-frame reset; serial_out SHALL be 1 at the edge following reset, and partial RX bytes SHALL be discarded.

Verification
REQ-026 SHALL cover this scenario: cfg_div=16, cfg_sample=8, 8N1, push 0xA5 -> serial_out low 16 cycles, then 1,0,1,0,0,1,0,1, then high; frame length 160 cycles; tx_busy is 1 throughout.
REQ-027 SHALL cover this scenario: serial_out looped to serial_in, 7 data bits, even parity, 2 stop bits, push 0x41 then 0x7F -> rx_data 0x41 then 0x7F, no errors, no idle gap on TX.
REQ-028 SHALL cover this scenario: 8E1 frame 0x03 driven with parity bit 1 -> rx_data=0x03, rx_parity_err=1; a frame driven with stop=0 -> rx_frame_err=1.
REQ-029 SHALL cover this scenario: FIFO_DEPTH=4, rx_ready=0, 5 frames received -> rx_level=4, 5th byte lost, rx_overrun=1; ovr_clr pulse -> 0.
REQ-030 SHALL cover this scenario: 4-cycle low glitch on serial_in with cfg_div=16, cfg_sample=8 -> no push, RX returns to IDLE.
REQ-031 SHALL cover this scenario: FIFO_DEPTH=8, 9 pushes while TX is busy -> tx_ready=0 at tx_level=8; reset mid-frame -> serial_out=1 next edge, all levels 0.
